// File: rtl/ser_to_par.sv
// ser_to_par: serial-to-parallel converter (receive side of par_to_ser).
// Collects bits from a 1-bit valid/ready stream into N-bit words. Each word
// is presented on a valid/ready parallel stream, together with a last flag and
// a count of the bits it holds. A one-word output register holds a finished
// word, so the next word can keep shifting in while downstream is stalled.
//
// Ports
//   clk        in   1             rising-edge clock
//   rst        in   1             synchronous active-high reset
//   ser_data   in   1             serial data bit
//   ser_valid  in   1             ser_data/ser_last are valid
//   ser_last   in   1             final bit of a frame; flushes a partial word
//   ser_ready  out  1             a serial bit is accepted this cycle
//   par_data   out  N             assembled word (unreceived positions are 0)
//   par_valid  out  1             par_data/par_last/par_nbits are valid
//   par_last   out  1             word was ended by ser_last
//   par_nbits  out  clog2(N+1)    number of received bits in par_data (1..N)
//   par_ready  in   1             downstream accepts the word
module ser_to_par #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ser_data,
  input  logic                   ser_valid,
  input  logic                   ser_last,
  output logic                   ser_ready,
  output logic [N-1:0]           par_data,
  output logic                   par_valid,
  output logic                   par_last,
  output logic [$clog2(N+1)-1:0] par_nbits,
  input  logic                   par_ready
);

  localparam int CW = $clog2(N + 1);
  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] LAST_IDX = BW'(N - 1);

  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] pos;
  logic [N-1:0]  shreg;
  logic [N-1:0]  shreg_nx;
  logic          at_end;
  logic          ser_beat;
  logic          word_done;

  assign at_end = (bit_cnt == LAST_IDX);

  // Only a completing bit needs the output register free; non-final bits
  // keep shifting while a finished word waits downstream.
  assign ser_ready = !par_valid || par_ready || (!at_end && !ser_last);
  assign ser_beat  = ser_valid && ser_ready;
  assign word_done = ser_beat && (at_end || ser_last);

  // Shift register with the current bit merged in; this is the word that is
  // loaded into the output register on completion.
  always_comb begin
    pos      = LSB_FIRST ? bit_cnt : (LAST_IDX - bit_cnt);
    shreg_nx = shreg;
    shreg_nx[pos] = ser_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      par_data  <= '0;
      par_valid <= 1'b0;
      par_last  <= 1'b0;
      par_nbits <= '0;
    end else begin
      if (ser_beat) begin
        if (word_done) begin
          bit_cnt <= '0;
          shreg   <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          shreg   <= shreg_nx;
        end
      end

      // A completion while the held word is being taken reloads directly,
      // keeping par_valid high with no bubble.
      if (word_done) begin
        par_data  <= shreg_nx;
        par_nbits <= CW'(bit_cnt) + CW'(1);
        par_last  <= ser_last;
        par_valid <= 1'b1;
      end else if (par_valid && par_ready) begin
        par_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ser_to_par.sv
module tb_ser_to_par;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  typedef struct {
    logic [N-1:0]  data;
    logic [CW-1:0] nbits;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ser_data = 1'b0;
  logic          ser_valid = 1'b0;
  logic          ser_last = 1'b0;
  logic          par_ready = 1'b1;

  logic          ser_ready, ser_ready_m;
  logic [N-1:0]  par_data, par_data_m;
  logic          par_valid, par_valid_m;
  logic          par_last, par_last_m;
  logic [CW-1:0] par_nbits, par_nbits_m;

  int n_cmp  = 0;
  int n_fail = 0;
  int stalls = 0;
  int pv_cycles = 0;
  int pops = 0;

  exp_t q_l[$];
  exp_t q_m[$];
  logic [N-1:0] mbits;
  int           mcnt = 0;

  always #5 clk = ~clk;

  ser_to_par #(.N(N), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .ser_data(ser_data), .ser_valid(ser_valid),
    .ser_last(ser_last), .ser_ready(ser_ready), .par_data(par_data),
    .par_valid(par_valid), .par_last(par_last), .par_nbits(par_nbits),
    .par_ready(par_ready)
  );

  ser_to_par #(.N(N), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .ser_data(ser_data), .ser_valid(ser_valid),
    .ser_last(ser_last), .ser_ready(ser_ready_m), .par_data(par_data_m),
    .par_valid(par_valid_m), .par_last(par_last_m), .par_nbits(par_nbits_m),
    .par_ready(par_ready)
  );

  // Reference model: record an accepted bit; on completion push the expected
  // word for both bit orders.
  task automatic model_accept(input logic d, input logic l);
    exp_t el, em;
    mbits[mcnt] = d;
    if (mcnt == N - 1 || l) begin
      el.data = '0;
      em.data = '0;
      for (int i = 0; i <= mcnt; i++) begin
        el.data[i]         = mbits[i];
        em.data[N - 1 - i] = mbits[i];
      end
      el.nbits = CW'(mcnt + 1);
      em.nbits = CW'(mcnt + 1);
      el.last  = l;
      em.last  = l;
      q_l.push_back(el);
      q_m.push_back(em);
      mcnt = 0;
    end else begin
      mcnt++;
    end
  endtask

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      n_cmp++;
      if (ser_ready !== ser_ready_m) begin
        n_fail++;
        $display("FAIL ser_ready_orders: lsb=%b msb=%b", ser_ready, ser_ready_m);
      end
      if (par_valid) pv_cycles++;
      if (par_valid && par_ready) begin
        pops++;
        n_cmp++;
        if (q_l.size() == 0) begin
          n_fail++;
          $display("FAIL lsb_unexpected_word: got %h", par_data);
        end else begin
          e = q_l.pop_front();
          if (par_data !== e.data || par_nbits !== e.nbits || par_last !== e.last) begin
            n_fail++;
            $display("FAIL lsb_word: got %h/%0d/%b want %h/%0d/%b",
                     par_data, par_nbits, par_last, e.data, e.nbits, e.last);
          end
        end
      end
      if (par_valid_m && par_ready) begin
        n_cmp++;
        if (q_m.size() == 0) begin
          n_fail++;
          $display("FAIL msb_unexpected_word: got %h", par_data_m);
        end else begin
          e = q_m.pop_front();
          if (par_data_m !== e.data || par_nbits_m !== e.nbits || par_last_m !== e.last) begin
            n_fail++;
            $display("FAIL msb_word: got %h/%0d/%b want %h/%0d/%b",
                     par_data_m, par_nbits_m, par_last_m, e.data, e.nbits, e.last);
          end
        end
      end
    end
  end

  task automatic send_bit(input logic d, input logic l);
    int w;
    w = 0;
    ser_valid = 1'b1;
    ser_data  = d;
    ser_last  = l;
    @(negedge clk);
    while (!ser_ready && w < 50) begin
      stalls++;
      w++;
      @(negedge clk);
    end
    if (!ser_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_bit_timeout: ser_ready=%b want 1", ser_ready);
    end else begin
      model_accept(d, l);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [N-1:0] v, input bit lsb_order);
    for (int i = 0; i < N; i++)
      send_bit(lsb_order ? v[i] : v[N - 1 - i], 1'b0);
  endtask

  task automatic idle();
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    ser_data  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mcnt = 0;
    q_l.delete();
    q_m.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      ser_valid = c[0] ? 1'b0 : 1'b1;
      ser_data  = 1'b1;
      ser_last  = c[0];
      @(posedge clk);
      #1;
      ser_valid = ~ser_valid;
      ser_data  = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (par_valid !== 1'b0 || ser_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_outputs: par_valid=%b ser_ready=%b want 0/1", par_valid, ser_ready);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    n_cmp++;
    if (par_data !== '0 || par_nbits !== '0 || par_last !== 1'b0 || par_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: data=%h nbits=%0d last=%b valid=%b want 0", par_data,
               par_nbits, par_last, par_valid);
    end
    @(posedge clk);
    #1;
    mcnt = 0;
    send_byte(8'h96, 1'b1);
    idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    par_ready = 1'b1;
    send_byte(8'd62, 1'b1);
    idle();
    @(negedge clk);
    n_cmp++;
    if (par_valid !== 1'b1 || par_data !== 8'd62 || par_nbits !== CW'(8) || par_last !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_lsb: valid=%b data=%0d nbits=%0d last=%b want 1/62/8/0",
               par_valid, par_data, par_nbits, par_last);
    end
    n_cmp++;
    if (par_data_m !== 8'd124) begin
      n_fail++;
      $display("FAIL basic_lsb_on_msb_dut: data=%0d want 124", par_data_m);
    end
    @(posedge clk);
    #1;
    send_byte(8'd62, 1'b0);
    idle();
    @(negedge clk);
    n_cmp++;
    if (par_valid_m !== 1'b1 || par_data_m !== 8'd62 || par_nbits_m !== CW'(8)) begin
      n_fail++;
      $display("FAIL basic_msb: valid=%b data=%0d nbits=%0d want 1/62/8",
               par_valid_m, par_data_m, par_nbits_m);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int s0;
    logic [N-1:0] v7;
    v7 = 8'd7;
    par_ready = 1'b0;
    send_byte(8'd52, 1'b1);
    s0 = stalls;
    for (int i = 0; i < N - 1; i++) send_bit(v7[i], 1'b0);
    n_cmp++;
    if (stalls != s0) begin
      n_fail++;
      $display("FAIL b2b_early_stall: stalls=%0d want 0", stalls - s0);
    end
    ser_valid = 1'b1;
    ser_data  = v7[N-1];
    ser_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (ser_ready !== 1'b0 || par_valid !== 1'b1 || par_data !== 8'd52) begin
        n_fail++;
        $display("FAIL b2b_hold: ser_ready=%b valid=%b data=%0d want 0/1/52",
                 ser_ready, par_valid, par_data);
      end
    end
    @(posedge clk);
    #1;
    par_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ser_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_release: ser_ready=%b want 1", ser_ready);
    end else begin
      model_accept(v7[N-1], 1'b0);
    end
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    n_cmp++;
    if (par_valid !== 1'b1 || par_data !== 8'd7) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b data=%0d want 1/7", par_valid, par_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_partial();
    par_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    idle();
    @(negedge clk);
    n_cmp++;
    if (par_data !== 8'h05 || par_nbits !== CW'(3) || par_last !== 1'b1 || par_data_m !== 8'hA0) begin
      n_fail++;
      $display("FAIL partial: data=%h nbits=%0d last=%b msb=%h want 05/3/1/a0",
               par_data, par_nbits, par_last, par_data_m);
    end
    @(posedge clk);
    #1;
    send_bit(1'b1, 1'b1);
    idle();
    @(negedge clk);
    n_cmp++;
    if (par_data !== 8'h01 || par_nbits !== CW'(1) || par_data_m !== 8'h80) begin
      n_fail++;
      $display("FAIL single_bit: data=%h nbits=%0d msb=%h want 01/1/80",
               par_data, par_nbits, par_data_m);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N - 1; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    idle();
    @(negedge clk);
    n_cmp++;
    if (par_data !== 8'h7F || par_nbits !== CW'(8) || par_last !== 1'b1) begin
      n_fail++;
      $display("FAIL full_last: data=%h nbits=%0d last=%b want 7f/8/1",
               par_data, par_nbits, par_last);
    end
    @(posedge clk);
    #1;
    send_byte(8'h3C, 1'b1);
    idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    int s0, pv0, p0;
    s0  = stalls;
    pv0 = pv_cycles;
    p0  = pops;
    par_ready = 1'b1;
    for (int w = 0; w < 5; w++) send_byte(N'($urandom_range(0, 255)), 1'b1);
    idle();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (stalls != s0 || pv_cycles - pv0 != 5 || pops - p0 != 5) begin
      n_fail++;
      $display("FAIL stream: stalls=%0d valid_cycles=%0d words=%0d want 0/5/5",
               stalls - s0, pv_cycles - pv0, pops - p0);
    end
  endtask

  task automatic test_reset_midword();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    do_reset();
    send_byte(8'hA5, 1'b1);
    idle();
    @(negedge clk);
    n_cmp++;
    if (par_valid !== 1'b1 || par_data !== 8'hA5 || par_nbits !== CW'(8)) begin
      n_fail++;
      $display("FAIL reset_midword: valid=%b data=%h nbits=%0d want 1/a5/8",
               par_valid, par_data, par_nbits);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_partial();
    test_stream();
    test_reset_midword();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (q_l.size() != 0 || q_m.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_words: lsb=%0d msb=%0d want 0/0", q_l.size(), q_m.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
